// File: rtl/terrain_probe_scheduler.sv
// terrain_probe_scheduler
//   Shares one single-port terrain map BRAM (2-bit cells) between the ball
//   physics probe set (centre, +x, -x, +y, -y) and a low-priority auxiliary
//   reader. One start pulse issues five probe reads back to back, drains the
//   BRAM pipeline, and then presents all five codes with a single probe_valid.
//
// Ports
//   clk_in, rst_in         clock, synchronous active-high reset
//   start, ball_x, ball_y  probe trigger and 8.8 ball position (latched on accept)
//   busy, probe_valid      sequence active / results-updated pulse
//   terrain_{c,xp,xm,yp,ym} probe results (held between probe_valid pulses)
//   start_dropped          sticky: start seen while a sequence was running
//   aux_req, aux_addr      auxiliary level request and cell address
//   aux_grant              aux_addr is on map_addr this cycle
//   aux_valid, aux_rdata   aux read return, RAM_LATENCY cycles after grant
//   map_addr, map_data     BRAM address out / read data in
module terrain_probe_scheduler #(
  parameter int unsigned WIDTH        = 160,
  parameter int unsigned HEIGHT       = 90,
  parameter logic [15:0] PROBE_OFFSET = 16'h0080,
  parameter int unsigned RAM_LATENCY  = 2,
  parameter logic [1:0]  WALL_CODE    = 2'd1
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        start,
  input  logic [15:0] ball_x,
  input  logic [15:0] ball_y,
  output logic        busy,
  output logic        probe_valid,
  output logic [1:0]  terrain_c,
  output logic [1:0]  terrain_xp,
  output logic [1:0]  terrain_xm,
  output logic [1:0]  terrain_yp,
  output logic [1:0]  terrain_ym,
  output logic        start_dropped,
  input  logic        aux_req,
  input  logic [15:0] aux_addr,
  output logic        aux_grant,
  output logic        aux_valid,
  output logic [1:0]  aux_rdata,
  output logic [15:0] map_addr,
  input  logic [1:0]  map_data
);

  localparam int DW = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  // Travels alongside each read so the returning datum finds its consumer.
  typedef struct packed {
    logic       vld;
    logic       aux;
    logic [2:0] idx;
    logic       oob;
  } tag_t;

  state_t                     state, state_nxt;
  logic   [2:0]               idx;
  logic   [DW-1:0]            drain_cnt;
  logic   [15:0]              bx, by;
  tag_t   [RAM_LATENCY-1:0]   tag_pipe;
  tag_t                       tag_new, tag_ret;
  logic   [4:0][1:0]          cap, cap_nxt;
  logic   [15:0]              addr_q;
  logic   [1:0]               aux_q;

  logic   [15:0]              cx, cy, cell_x, cell_y, probe_addr;
  logic                       probe_oob, issuing, start_ok;

  // Probe coordinate for the current index, 16-bit wrapping.
  always_comb begin
    cx = bx;
    cy = by;
    unique case (idx)
      3'd1:    cx = bx + PROBE_OFFSET;
      3'd2:    cx = bx - PROBE_OFFSET;
      3'd3:    cy = by + PROBE_OFFSET;
      3'd4:    cy = by - PROBE_OFFSET;
      default: ;
    endcase
  end

  // Integer cell; a coordinate that wrapped below zero lands on cell 255
  // and is caught by the bounds test.
  assign cell_x     = cx >> 8;
  assign cell_y     = cy >> 8;
  assign probe_addr = cell_x + 16'(WIDTH) * cell_y;
  assign probe_oob  = (cell_x >= 16'(WIDTH)) || (cell_y >= 16'(HEIGHT));

  assign issuing     = (state == ISSUE);
  assign start_ok    = start && (state == IDLE);
  assign busy        = (state != IDLE);
  assign probe_valid = (state == DONE);

  // Start wins over aux in the same cycle.
  assign aux_grant = (state == IDLE) && aux_req && !start && !rst_in;
  assign map_addr  = issuing ? probe_addr : (aux_grant ? aux_addr : addr_q);

  assign tag_new = '{vld: issuing || aux_grant, aux: aux_grant,
                     idx: idx, oob: issuing && probe_oob};
  assign tag_ret = tag_pipe[RAM_LATENCY-1];

  assign aux_valid = tag_ret.vld && tag_ret.aux && !rst_in;
  assign aux_rdata = aux_valid ? map_data : aux_q;

  // Probe captures including the datum returning this cycle, so the last
  // probe's result can be published on the same edge that enters DONE.
  always_comb begin
    cap_nxt = cap;
    if (tag_ret.vld && !tag_ret.aux)
      cap_nxt[tag_ret.idx] = tag_ret.oob ? WALL_CODE : map_data;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (start) state_nxt = ISSUE;
      ISSUE: if (idx == 3'd4) state_nxt = DRAIN;
      DRAIN: if (drain_cnt == DW'(RAM_LATENCY - 1)) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state         <= IDLE;
      idx           <= '0;
      drain_cnt     <= '0;
      bx            <= '0;
      by            <= '0;
      tag_pipe      <= '0;
      cap           <= '0;
      terrain_c     <= '0;
      terrain_xp    <= '0;
      terrain_xm    <= '0;
      terrain_yp    <= '0;
      terrain_ym    <= '0;
      start_dropped <= 1'b0;
      addr_q        <= '0;
      aux_q         <= '0;
    end else begin
      state <= state_nxt;
      if (start_ok) begin
        bx <= ball_x;
        by <= ball_y;
      end
      if (start_ok)     idx <= '0;
      else if (issuing) idx <= idx + 3'd1;
      drain_cnt <= (state == DRAIN) ? drain_cnt + DW'(1) : '0;

      tag_pipe[0] <= tag_new;
      for (int i = 1; i < RAM_LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];

      cap <= cap_nxt;
      if (state == DRAIN && state_nxt == DONE) begin
        terrain_c  <= cap_nxt[0];
        terrain_xp <= cap_nxt[1];
        terrain_xm <= cap_nxt[2];
        terrain_yp <= cap_nxt[3];
        terrain_ym <= cap_nxt[4];
      end

      if (start && state != IDLE) start_dropped <= 1'b1;
      addr_q <= map_addr;
      aux_q  <= aux_rdata;
    end
  end

endmodule

// File: tb/tb_terrain_probe_scheduler.sv
module tb_terrain_probe_scheduler;

  logic        clk_in = 1'b0;
  logic        rst_in, start, aux_req;
  logic [15:0] ball_x, ball_y, aux_addr;
  logic        busy, probe_valid, start_dropped, aux_grant, aux_valid;
  logic [1:0]  terrain_c, terrain_xp, terrain_xm, terrain_yp, terrain_ym;
  logic [1:0]  aux_rdata, map_data;
  logic [15:0] map_addr;

  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  terrain_probe_scheduler dut (
    .clk_in(clk_in), .rst_in(rst_in), .start(start), .ball_x(ball_x), .ball_y(ball_y),
    .busy(busy), .probe_valid(probe_valid),
    .terrain_c(terrain_c), .terrain_xp(terrain_xp), .terrain_xm(terrain_xm),
    .terrain_yp(terrain_yp), .terrain_ym(terrain_ym),
    .start_dropped(start_dropped), .aux_req(aux_req), .aux_addr(aux_addr),
    .aux_grant(aux_grant), .aux_valid(aux_valid), .aux_rdata(aux_rdata),
    .map_addr(map_addr), .map_data(map_data)
  );

  // BRAM model: two-cycle read latency.
  logic [1:0] mem [0:65535];
  logic [1:0] d1;
  initial begin
    d1 = '0;
    map_data = '0;
  end
  always @(posedge clk_in) begin
    d1       <= mem[map_addr];
    map_data <= d1;
  end

  // Observations of one probe sequence, filled by do_probe.
  logic [15:0] obs_addr [5];
  logic [9:0]  obs_t;
  int          pv_cnt, pv_cyc, busy_bad;

  function automatic logic [9:0] terr();
    return {terrain_c, terrain_xp, terrain_xm, terrain_yp, terrain_ym};
  endfunction

  // Stimulus only: pulse start and record what the DUT does for 12 cycles.
  task automatic do_probe(input logic [15:0] x, input logic [15:0] y);
    ball_x = x; ball_y = y; start = 1'b1;
    @(negedge clk_in);
    start = 1'b0;
    pv_cnt = 0; pv_cyc = 0; busy_bad = 0; obs_t = '0;
    for (int c = 1; c <= 12; c++) begin
      if (c <= 5) obs_addr[c-1] = map_addr;
      if (probe_valid === 1'b1) begin
        pv_cnt++; pv_cyc = c; obs_t = terr();
      end
      if (busy !== (c <= 8)) busy_bad++;
      @(negedge clk_in);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({busy, probe_valid, start_dropped, aux_grant, aux_valid} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 00000",
                         {busy, probe_valid, start_dropped, aux_grant, aux_valid});
    end
    checks++;
    if (terr() !== 10'd0) begin
      errors++; $display("FAIL reset_terrain: got %h expected 000", terr());
    end
    checks++;
    if (map_addr !== 16'd0 || aux_rdata !== 2'd0) begin
      errors++; $display("FAIL reset_addr_rdata: got %h/%h expected 0/0", map_addr, aux_rdata);
    end
  endtask

  task automatic test_centre();
    logic [15:0] ea [5];
    ea = '{16'd1610, 16'd1610, 16'd1609, 16'd1610, 16'd1450};
    do_probe(16'h0A00, 16'h0A00);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (obs_addr[k] !== ea[k]) begin
        errors++; $display("FAIL centre_addr%0d: got %0d expected %0d", k, obs_addr[k], ea[k]);
      end
    end
    checks++;
    if (pv_cnt !== 1 || pv_cyc !== 8) begin
      errors++; $display("FAIL centre_pv: got count %0d cycle %0d expected 1 at 8", pv_cnt, pv_cyc);
    end
    checks++;
    if (busy_bad !== 0) begin
      errors++; $display("FAIL centre_busy: got %0d bad cycles expected 0", busy_bad);
    end
    checks++;
    if (obs_t !== 10'b10_10_10_10_10) begin
      errors++; $display("FAIL centre_terrain: got %b expected 1010101010", obs_t);
    end
    checks++;
    if (terr() !== 10'b10_10_10_10_10) begin
      errors++; $display("FAIL centre_hold: got %b expected 1010101010", terr());
    end
  endtask

  task automatic test_wall();
    do_probe(16'h0A80, 16'h0A00);
    checks++;
    if (obs_addr[1] !== 16'd1611) begin
      errors++; $display("FAIL wall_addr_xp: got %0d expected 1611", obs_addr[1]);
    end
    checks++;
    if (pv_cnt !== 1 || obs_t !== 10'b10_01_10_10_10) begin
      errors++; $display("FAIL wall_terrain: got %b (pulses %0d) expected 1001101010 (1)", obs_t, pv_cnt);
    end
  endtask

  task automatic test_out_of_bounds();
    // xm wraps to cell 255; the BRAM holds grass there but wall is reported.
    do_probe(16'h0040, 16'h0A00);
    checks++;
    if (obs_addr[2] !== 16'd1855) begin
      errors++; $display("FAIL oob_x_addr: got %0d expected 1855", obs_addr[2]);
    end
    checks++;
    if (obs_t !== 10'b10_10_01_10_00) begin
      errors++; $display("FAIL oob_x_terrain: got %b expected 1010011000", obs_t);
    end
    // py = 90 on c/xp/xm/yp; ym (py = 89) is in range and reads a hole.
    do_probe(16'h0A00, 16'h5A00);
    checks++;
    if (obs_addr[0] !== 16'd14410 || obs_addr[4] !== 16'd14250) begin
      errors++; $display("FAIL oob_y_addr: got %0d/%0d expected 14410/14250", obs_addr[0], obs_addr[4]);
    end
    checks++;
    if (obs_t !== 10'b01_01_01_01_00 || pv_cnt !== 1) begin
      errors++; $display("FAIL oob_y_terrain: got %b expected 0101010100", obs_t);
    end
  endtask

  task automatic test_aux_overlap();
    logic [15:0] aa [3];
    logic [1:0]  ad [3];
    int pv_at, extra_av;
    aa = '{16'd1611, 16'd1440, 16'd20000};
    ad = '{2'd1, 2'd0, 2'd3};
    pv_at = 0; extra_av = 0;
    for (int k = 0; k < 3; k++) begin
      aux_req = 1'b1; aux_addr = aa[k]; #1;
      checks++;
      if (aux_grant !== 1'b1 || map_addr !== aa[k]) begin
        errors++; $display("FAIL aux_grant%0d: got %b addr %0d expected 1 addr %0d",
                           k, aux_grant, map_addr, aa[k]);
      end
      checks++;
      if (aux_valid !== (k == 2) || (k == 2 && aux_rdata !== ad[0])) begin
        errors++; $display("FAIL aux_ret0_c%0d: got %b data %0d expected %b data %0d",
                           k, aux_valid, aux_rdata, (k == 2), ad[0]);
      end
      @(negedge clk_in);
    end
    // Start coincides with the fourth aux request cycle.
    aux_addr = 16'd5; ball_x = 16'h0A00; ball_y = 16'h0A00; start = 1'b1; #1;
    checks++;
    if (aux_grant !== 1'b0) begin
      errors++; $display("FAIL aux_no_grant_on_start: got %b expected 0", aux_grant);
    end
    checks++;
    if (aux_valid !== 1'b1 || aux_rdata !== ad[1]) begin
      errors++; $display("FAIL aux_ret1: got %b data %0d expected 1 data %0d", aux_valid, aux_rdata, ad[1]);
    end
    @(negedge clk_in);
    start = 1'b0; aux_req = 1'b0; #1;
    checks++;
    if (aux_valid !== 1'b1 || aux_rdata !== ad[2] || busy !== 1'b1 || map_addr !== 16'd1610) begin
      errors++; $display("FAIL aux_ret2: got v%b d%0d busy%b addr%0d expected v1 d%0d busy1 addr1610",
                         aux_valid, aux_rdata, busy, map_addr, ad[2]);
    end
    for (int c = 2; c <= 12; c++) begin
      @(negedge clk_in);
      if (aux_valid === 1'b1) extra_av++;
      if (probe_valid === 1'b1) begin
        pv_at = c; obs_t = terr();
      end
    end
    checks++;
    if (pv_at !== 8 || obs_t !== 10'b10_10_10_10_10) begin
      errors++; $display("FAIL aux_probe_result: got cycle %0d terrain %b expected 8 1010101010", pv_at, obs_t);
    end
    checks++;
    if (extra_av !== 0 || aux_rdata !== 2'd3) begin
      errors++; $display("FAIL aux_hold: got extra %0d data %0d expected 0 data 3", extra_av, aux_rdata);
    end
  endtask

  task automatic test_drop_reset();
    int bad;
    bad = 0;
    ball_x = 16'h0A00; ball_y = 16'h0A00; start = 1'b1;
    @(negedge clk_in);                 // cycle t+1
    start = 1'b0;
    repeat (3) @(negedge clk_in);      // cycle t+4
    start = 1'b1;
    @(negedge clk_in);                 // cycle t+5
    start = 1'b0; #1;
    checks++;
    if (start_dropped !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL drop_flag: got dropped %b busy %b expected 1 1", start_dropped, busy);
    end
    @(negedge clk_in);                 // cycle t+6
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0; #1;
    checks++;
    if ({busy, probe_valid, start_dropped, aux_grant, aux_valid} !== 5'b0 ||
        terr() !== 10'd0 || map_addr !== 16'd0 || aux_rdata !== 2'd0) begin
      errors++; $display("FAIL reset_mid_seq: got flags %b terrain %h addr %0d rdata %0d expected all 0",
                         {busy, probe_valid, start_dropped, aux_grant, aux_valid}, terr(), map_addr, aux_rdata);
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_in);
      if (probe_valid !== 1'b0 || aux_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL reset_discard: got %0d stray pulses expected 0", bad);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 2'd3;
    mem[1610] = 2'd2; mem[1609] = 2'd2; mem[1450] = 2'd2; mem[1611] = 2'd1;
    mem[1600] = 2'd2; mem[1440] = 2'd0; mem[1855] = 2'd2;
    mem[14410] = 2'd2; mem[14409] = 2'd2; mem[14250] = 2'd0;
    rst_in = 1'b1; start = 1'b0; aux_req = 1'b0;
    ball_x = '0; ball_y = '0; aux_addr = '0;
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0; #1;
    test_reset();
    @(negedge clk_in);
    test_centre();
    test_wall();
    test_out_of_bounds();
    test_aux_overlap();
    test_drop_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
